// File: rtl/approx_result_denormalizer_pkg.sv
// Shared constants, state encoding and helpers for the result denormalizer.
package approx_result_denormalizer_pkg;

  localparam int PROD_W = 16;          // truncated product width
  localparam int OUT_W  = 2 * PROD_W;  // reconstructed result width
  localparam int SH_W   = 4;           // per-operand shift count width
  localparam int CNT_W  = SH_W + 1;    // holds 2*(2^SH_W-1) without overflow

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    SHIFT = S_SHIFT,
    DONE  = S_DONE
  } state_t;

  // Total right shifts needed: both counts zero-extended so the sum never wraps.
  function automatic logic [CNT_W-1:0] shift_sum(input logic [SH_W-1:0] a,
                                                 input logic [SH_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/approx_result_denormalizer_shift_reg.sv
// Result shift register: loads the product into the upper half, shifts right
// one bit per enabled cycle. Priority is clear > load > shift.
module denorm_shift_reg
  import approx_result_denormalizer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load_hi,
  input  logic              shift_en,
  input  logic [PROD_W-1:0] din,
  output logic [OUT_W-1:0]  q
);

  logic [OUT_W-1:0] data_reg;

  // Register update; bits shifted out of the bottom are simply dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_reg <= '0;
    end else if (clear) begin
      data_reg <= '0;
    end else if (load_hi) begin
      data_reg <= {din, {PROD_W{1'b0}}};
    end else if (shift_en) begin
      data_reg <= {1'b0, data_reg[OUT_W-1:1]};
    end
  end

  assign q = data_reg;

endmodule

// File: rtl/approx_result_denormalizer.sv
// Rebuilds the full-scale product from the truncated normalized product by
// shifting it right once per cycle, shift_a+shift_b times.
module approx_result_denormalizer
  import approx_result_denormalizer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  input  logic [SH_W-1:0]   shift_a,
  input  logic [SH_W-1:0]   shift_b,
  input  logic              zero_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  result,
  output logic              busy
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] load_cnt;
  logic             sr_clear, sr_load, sr_shift;

  assign load_cnt = shift_sum(shift_a, shift_b);

  // State and shift-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state, counter and shift-register control.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sr_clear   = 1'b0;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (zero_op) begin
            // A zero operand means a zero product: skip straight to DONE.
            sr_clear   = 1'b1;
            cnt_next   = '0;
            state_next = DONE;
          end else begin
            sr_load    = 1'b1;
            cnt_next   = load_cnt;
            state_next = (load_cnt != '0) ? SHIFT : DONE;
          end
        end
      end
      SHIFT: begin
        sr_shift = 1'b1;
        cnt_next = cnt_reg - CNT_W'(1);
        // cnt==1 is the last shift; <=1 also guards against a stuck zero count.
        if (cnt_reg <= CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  denorm_shift_reg u_shift_reg (
    .clk      (clk),
    .rst      (rst),
    .clear    (sr_clear),
    .load_hi  (sr_load),
    .shift_en (sr_shift),
    .din      (product),
    .q        (result)
  );

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_approx_result_denormalizer.sv
// Self-checking bench for approx_result_denormalizer: directed plan vectors,
// backpressure, mid-shift reset and randomized bundles against a reference.
module tb_approx_result_denormalizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] product = '0;
  logic [3:0]  shift_a = '0;
  logic [3:0]  shift_b = '0;
  logic        zero_op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  approx_result_denormalizer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .shift_a   (shift_a),
    .shift_b   (shift_b),
    .zero_op   (zero_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  // Reference: the full-scale value is product*2^16 divided by 2^(a+b),
  // truncated; a zero operand gives zero. Latency is a+b+1 edges from accept.
  function automatic logic [31:0] ref_result(input logic [15:0] p, input int a,
                                             input int b, input bit z);
    longint unsigned full;
    if (z) return 32'd0;
    full = longint'(p) * 64'd65536;
    full = full / (64'd1 << (a + b));
    return full[31:0];
  endfunction

  function automatic int ref_latency(input int a, input int b, input bit z);
    return z ? 1 : a + b + 1;
  endfunction

  // Drives one bundle and collects observations; called 1 time unit after a
  // rising edge and returns at the same alignment, after the result handshake.
  task automatic do_txn(input logic [15:0] p, input logic [3:0] a, input logic [3:0] b,
                        input bit z, input int hold,
                        output bit pre_ready, output int lat, output logic [31:0] res,
                        output bit ready_low, output bit stable, output bit busy_ok,
                        output bit post_ready, output bit post_valid, output bit timeout);
    pre_ready = in_ready;
    product = p; shift_a = a; shift_b = b; zero_op = z; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; zero_op = 1'b0;
    lat = 1; ready_low = 1'b1; busy_ok = 1'b1; timeout = 1'b0;
    while (!out_valid) begin
      if (in_ready) ready_low = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (lat > 64) begin
        timeout = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    if (in_ready || !busy) ready_low = 1'b0;
    stable = 1'b1;
    // Present a conflicting bundle while stalled; it must be ignored.
    product = 16'h5A5A; shift_a = 4'd1; shift_b = 4'd2; in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!out_valid || result !== res || in_ready) stable = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    post_ready = in_ready;
    post_valid = out_valid;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #3;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b result=%h, want 1 0 0 00000000",
               in_ready, out_valid, busy, result);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Runs one bundle and checks every observation against the reference.
  task automatic check_bundle(input string name, input logic [15:0] p, input int a,
                              input int b, input bit z, input int hold);
    bit pre_r, rl, st, bz, pr, pv, to;
    int lat;
    logic [31:0] res, exp_res;
    int exp_lat;
    exp_res = ref_result(p, a, b, z);
    exp_lat = ref_latency(a, b, z);
    do_txn(p, 4'(a), 4'(b), z, hold, pre_r, lat, res, rl, st, bz, pr, pv, to);
    tests_run++;
    if (to || pre_r !== 1'b1 || lat != exp_lat || res !== exp_res) begin
      tests_failed++;
      $display("FAIL %s: p=%h a=%0d b=%0d z=%b got result=%h latency=%0d ready_before=%b timeout=%b, want result=%h latency=%0d ready_before=1",
               name, p, a, b, z, res, lat, pre_r, to, exp_res, exp_lat);
    end
    tests_run++;
    if (!rl || !bz || !st) begin
      tests_failed++;
      $display("FAIL %s_ctrl: in_ready_low=%b busy_high=%b stall_stable=%b, want 1 1 1",
               name, rl, bz, st);
    end
    tests_run++;
    if (pr !== 1'b1 || pv !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_handshake: after accept in_ready=%b out_valid=%b, want 1 0", name, pr, pv);
    end
    $display("[TB] %s p=%h a=%0d b=%0d z=%b hold=%0d -> result=%h latency=%0d",
             name, p, a, b, z, hold, res, lat);
  endtask

  task automatic test_directed();
    check_bundle("n0",     16'hABCD, 0, 0, 1'b0, 0);
    check_bundle("n8",     16'hABCD, 4, 4, 1'b0, 0);
    check_bundle("n30",    16'hABCD, 15, 15, 1'b0, 0);
    check_bundle("zero_op", 16'hFFFF, 3, 0, 1'b1, 0);
  endtask

  task automatic test_backpressure();
    check_bundle("backpressure", 16'h8000, 1, 0, 1'b0, 5);
  endtask

  task automatic test_reset_mid_shift();
    product = 16'hF00F; shift_a = 4'd5; shift_b = 4'd5; zero_op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    tests_run++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_shift_busy: busy=%b out_valid=%b, want 1 0", busy, out_valid);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || result !== 32'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_shift_reset: out_valid=%b result=%h in_ready=%b busy=%b, want 0 00000000 1 0",
               out_valid, result, in_ready, busy);
    end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check_bundle("after_reset", 16'h0001, 0, 0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    check_bundle("b2b_0", 16'h1234, 2, 3, 1'b0, 0);
    check_bundle("b2b_1", 16'hFFFF, 0, 1, 1'b0, 0);
    check_bundle("b2b_2", 16'h8001, 7, 0, 1'b0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      logic [15:0] p;
      int a, b, hold;
      bit z;
      p    = 16'($urandom);
      a    = int'($urandom_range(0, 15));
      b    = int'($urandom_range(0, 15));
      z    = ($urandom_range(0, 7) == 0);
      hold = int'($urandom_range(0, 3));
      check_bundle($sformatf("rand%0d", i), p, a, b, z, hold);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule
